// File: rtl/a23_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the Amber23 system bus.
// Registered round-robin grant held for the whole cycle, with a strobe watchdog.
module a23_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic        i_clk,
   input  logic        globrst_n,
   input  logic [31:0] i_m0_adr,
   input  logic [3:0]  i_m0_sel,
   input  logic        i_m0_we,
   input  logic [31:0] i_m0_dat,
   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   output logic [31:0] o_m0_dat,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   input  logic [31:0] i_m1_adr,
   input  logic [3:0]  i_m1_sel,
   input  logic        i_m1_we,
   input  logic [31:0] i_m1_dat,
   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   output logic [31:0] o_m1_dat,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_s_adr,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic [31:0] o_s_dat,
   output logic        o_s_cyc,
   output logic        o_s_stb,
   input  logic [31:0] i_s_dat,
   input  logic        i_s_ack,
   input  logic        i_s_err,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             last_gnt_q, last_gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt0, gnt1;
   logic             mCyc, mStb, stbAct, wdErr;

   always_ff @(posedge i_clk) begin
      if (!globrst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

   // On a tie the master that was not granted last time wins.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE: begin
            if (i_m0_cyc && (!i_m1_cyc || last_gnt_q)) begin
               state_d    = GNT0;
               last_gnt_d = 1'b0;
            end else if (i_m1_cyc) begin
               state_d    = GNT1;
               last_gnt_d = 1'b1;
            end
         end
         GNT0:    if (!i_m0_cyc) state_d = IDLE;
         GNT1:    if (!i_m1_cyc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grants are qualified with reset so every output reads zero while it is held.
   assign gnt0 = (state_q == GNT0) && globrst_n;
   assign gnt1 = (state_q == GNT1) && globrst_n;

   always_comb begin
      o_s_adr = '0;
      o_s_sel = '0;
      o_s_we  = 1'b0;
      o_s_dat = '0;
      mCyc    = 1'b0;
      mStb    = 1'b0;
      if (gnt0) begin
         o_s_adr = i_m0_adr;
         o_s_sel = i_m0_sel;
         o_s_we  = i_m0_we;
         o_s_dat = i_m0_dat;
         mCyc    = i_m0_cyc;
         mStb    = i_m0_stb;
      end else if (gnt1) begin
         o_s_adr = i_m1_adr;
         o_s_sel = i_m1_sel;
         o_s_we  = i_m1_we;
         o_s_dat = i_m1_dat;
         mCyc    = i_m1_cyc;
         mStb    = i_m1_stb;
      end
   end

   assign stbAct = mCyc && mStb;
   assign wdErr  = stbAct && (cnt_q == FIRE_AT) && !i_s_ack;

   // The counter only runs over an unbroken, unanswered strobe within one grant.
   always_comb begin
      cnt_d = '0;
      if (stbAct && !i_s_ack && !i_s_err && !wdErr && (state_d == state_q))
         cnt_d = cnt_q + 1'b1;
   end

   assign o_s_cyc   = mCyc;
   assign o_s_stb   = stbAct && !wdErr;
   assign o_timeout = wdErr;
   assign o_grant   = {gnt1, gnt0};

   assign o_m0_dat = gnt0 ? i_s_dat : 32'h0;
   assign o_m0_ack = gnt0 && i_s_ack;
   assign o_m0_err = gnt0 && (i_s_err || wdErr);
   assign o_m1_dat = gnt1 ? i_s_dat : 32'h0;
   assign o_m1_ack = gnt1 && i_s_ack;
   assign o_m1_err = gnt1 && (i_s_err || wdErr);

endmodule

// File: tb/tb_a23_wb_arbiter.sv
// Directed self-checking bench for a23_wb_arbiter with a hand-driven slave.
module tb_a23_wb_arbiter;

   logic        i_clk = 1'b0;
   logic        globrst_n;
   logic [31:0] i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat, i_s_dat;
   logic [3:0]  i_m0_sel, i_m1_sel;
   logic        i_m0_we, i_m1_we, i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb;
   logic        i_s_ack, i_s_err;
   logic [31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic [3:0]  o_s_sel;
   logic        o_s_we, o_s_cyc, o_s_stb, o_timeout;
   logic [1:0]  o_grant;

   int totalCount = 0;
   int badCount   = 0;

   a23_wb_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
      .i_clk(i_clk), .globrst_n(globrst_n),
      .i_m0_adr(i_m0_adr), .i_m0_sel(i_m0_sel), .i_m0_we(i_m0_we), .i_m0_dat(i_m0_dat),
      .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .i_m1_adr(i_m1_adr), .i_m1_sel(i_m1_sel), .i_m1_we(i_m1_we), .i_m1_dat(i_m1_dat),
      .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_s_adr(o_s_adr), .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_dat(o_s_dat),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation ran past its time limit");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      if (obs !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge, then let combinational outputs settle.
   task automatic nextCycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic [31:0] dat);
      if (m == 0) begin
         i_m0_cyc = cyc; i_m0_stb = stb; i_m0_we = we; i_m0_adr = adr; i_m0_dat = dat;
         i_m0_sel = 4'hF;
      end else begin
         i_m1_cyc = cyc; i_m1_stb = stb; i_m1_we = we; i_m1_adr = adr; i_m1_dat = dat;
         i_m1_sel = 4'hF;
      end
   endtask

   task automatic applyReset();
      globrst_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      i_s_dat = 32'h0; i_s_ack = 1'b0; i_s_err = 1'b0;
      nextCycle();
      nextCycle();
      globrst_n = 1'b1;
      #1;
   endtask

   initial begin
      $display("[TB] starting a23_wb_arbiter bench");
      applyReset();
      checkOutput("rst_grant", 32'(o_grant), 32'h0);
      checkOutput("rst_s_cyc", 32'(o_s_cyc), 32'h0);

      // Single master read with a one-cycle-late ack.
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
      #1;
      checkOutput("t1_idle_grant", 32'(o_grant), 32'h0);
      checkOutput("t1_idle_stb", 32'(o_s_stb), 32'h0);
      nextCycle();
      checkOutput("t1_grant", 32'(o_grant), 32'h1);
      checkOutput("t1_s_adr", o_s_adr, 32'h0000_0100);
      checkOutput("t1_s_stb", 32'(o_s_stb), 32'h1);
      nextCycle();
      i_s_ack = 1'b1; i_s_dat = 32'hDEAD_BEEF;
      #1;
      checkOutput("t1_m0_ack", 32'(o_m0_ack), 32'h1);
      checkOutput("t1_m0_dat", o_m0_dat, 32'hDEAD_BEEF);
      checkOutput("t1_m1_ack", 32'(o_m1_ack), 32'h0);
      checkOutput("t1_m1_dat", o_m1_dat, 32'h0);
      nextCycle();
      i_s_ack = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("t1_release", 32'(o_grant), 32'h0);

      // Tie after reset, then round-robin.
      applyReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0A00, 32'h0000_0011);
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0B00, 32'h0000_0022);
      nextCycle();
      checkOutput("t2_first_grant", 32'(o_grant), 32'h1);
      checkOutput("t2_s_dat_m0", o_s_dat, 32'h0000_0011);
      checkOutput("t2_s_we", 32'(o_s_we), 32'h1);
      i_s_ack = 1'b1;
      #1;
      checkOutput("t2_m0_ack", 32'(o_m0_ack), 32'h1);
      checkOutput("t2_m1_ack_blocked", 32'(o_m1_ack), 32'h0);
      nextCycle();
      i_s_ack = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("t2_gap_idle", 32'(o_grant), 32'h0);
      nextCycle();
      checkOutput("t2_second_grant", 32'(o_grant), 32'h2);
      checkOutput("t2_s_dat_m1", o_s_dat, 32'h0000_0022);
      checkOutput("t2_s_adr_m1", o_s_adr, 32'h0000_0B00);
      i_s_ack = 1'b1;
      #1;
      checkOutput("t2_m1_ack", 32'(o_m1_ack), 32'h1);
      nextCycle();
      i_s_ack = 1'b0;
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("t2_idle2", 32'(o_grant), 32'h0);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0000_0A04, 32'h0000_0033);
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0B04, 32'h0000_0044);
      nextCycle();
      checkOutput("t2_rr_tie", 32'(o_grant), 32'h1);

      // m1 holds the grant over four back-to-back writes while m0 waits.
      applyReset();
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'd2);
      nextCycle();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
      begin
         logic [31:0] holdData [4];
         holdData[0] = 32'd2; holdData[1] = 32'd3; holdData[2] = 32'd5; holdData[3] = 32'd0;
         for (int k = 0; k < 4; k++) begin
            i_m1_dat = holdData[k];
            i_s_ack  = 1'b1;
            #1;
            checkOutput($sformatf("t3_grant_%0d", k), 32'(o_grant), 32'h2);
            checkOutput($sformatf("t3_s_dat_%0d", k), o_s_dat, holdData[k]);
            checkOutput($sformatf("t3_s_adr_%0d", k), o_s_adr, 32'h1000_0000);
            checkOutput($sformatf("t3_m0_ack_%0d", k), 32'(o_m0_ack), 32'h0);
            nextCycle();
         end
      end
      i_s_ack = 1'b0;
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("t3_gap_idle", 32'(o_grant), 32'h0);
      nextCycle();
      checkOutput("t3_m0_after", 32'(o_grant), 32'h1);

      // Watchdog fires on the eighth unanswered strobe cycle.
      applyReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
      nextCycle();
      for (int k = 1; k <= 7; k++) begin
         checkOutput($sformatf("t4_stb_c%0d", k), 32'(o_s_stb), 32'h1);
         checkOutput($sformatf("t4_to_c%0d", k), 32'(o_timeout), 32'h0);
         nextCycle();
      end
      checkOutput("t4_fire_err", 32'(o_m0_err), 32'h1);
      checkOutput("t4_fire_timeout", 32'(o_timeout), 32'h1);
      checkOutput("t4_fire_stb", 32'(o_s_stb), 32'h0);
      checkOutput("t4_fire_cyc", 32'(o_s_cyc), 32'h1);
      nextCycle();
      checkOutput("t4_hold_grant", 32'(o_grant), 32'h1);
      checkOutput("t4_after_stb", 32'(o_s_stb), 32'h1);
      checkOutput("t4_after_timeout", 32'(o_timeout), 32'h0);
      i_s_ack = 1'b1; i_s_err = 1'b1;
      #1;
      checkOutput("t4_both_ack", 32'(o_m0_ack), 32'h1);
      checkOutput("t4_both_err", 32'(o_m0_err), 32'h1);
      nextCycle();
      i_s_ack = 1'b0; i_s_err = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("t4_release", 32'(o_grant), 32'h0);

      // Ack in exactly the watchdog cycle wins over the timeout.
      applyReset();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
      nextCycle();
      for (int k = 1; k <= 7; k++) nextCycle();
      i_s_ack = 1'b1; i_s_dat = 32'h0000_0055;
      #1;
      checkOutput("t5_ack", 32'(o_m0_ack), 32'h1);
      checkOutput("t5_err", 32'(o_m0_err), 32'h0);
      checkOutput("t5_timeout", 32'(o_timeout), 32'h0);
      checkOutput("t5_stb", 32'(o_s_stb), 32'h1);
      checkOutput("t5_dat", o_m0_dat, 32'h0000_0055);
      nextCycle();
      i_s_ack = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();

      // Reset in the middle of an m1 transfer.
      applyReset();
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0077);
      nextCycle();
      checkOutput("t6_pre_grant", 32'(o_grant), 32'h2);
      checkOutput("t6_pre_cyc", 32'(o_s_cyc), 32'h1);
      globrst_n = 1'b0;
      i_s_ack = 1'b1;
      #1;
      checkOutput("t6_inrst_ack", 32'(o_m1_ack), 32'h0);
      nextCycle();
      checkOutput("t6_post_grant", 32'(o_grant), 32'h0);
      checkOutput("t6_post_cyc", 32'(o_s_cyc), 32'h0);
      checkOutput("t6_post_stb", 32'(o_s_stb), 32'h0);
      checkOutput("t6_post_ack", 32'(o_m1_ack), 32'h0);
      globrst_n = 1'b1;
      i_s_ack = 1'b0;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
      nextCycle();
      checkOutput("t6_tie_after_rst", 32'(o_grant), 32'h1);
      checkOutput("t6_s_adr", o_s_adr, 32'h0000_0400);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
